// File: rtl/sequence_generator.sv
// Serial pattern transmitter: loads a parallel pattern, sends it MSB-first repeat_cnt+1 times,
// then pulses done. Define SEQGEN_PARITY_EN to append an even-parity bit after each repetition.
module sequence_generator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             serialOutput,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BitW = $clog2(WIDTH + 1);
`ifdef SEQGEN_PARITY_EN
  // Counter index WIDTH is the parity slot.
  localparam logic [BitW-1:0] LastBit = BitW'(WIDTH);
`else
  localparam logic [BitW-1:0] LastBit = BitW'(WIDTH - 1);
`endif

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_shadow, w_shadow_d;
  logic [WIDTH-1:0] r_shift, w_shift_d;
  logic [BitW-1:0]  r_bit_cnt, w_bit_cnt_d;
  logic [CNT_W-1:0] r_rep, w_rep_d;
  logic             r_serial, r_bit_valid, r_busy, r_done, r_load_ready;
  logic             w_tx_bit;

  always_comb begin
    w_state_d   = r_state;
    w_shadow_d  = r_shadow;
    w_shift_d   = r_shift;
    w_bit_cnt_d = r_bit_cnt;
    w_rep_d     = r_rep;
    case (r_state)
      StIdle: begin
        if (load_valid) begin
          w_shadow_d  = pattern;
          w_shift_d   = pattern;
          w_rep_d     = repeat_cnt;
          w_bit_cnt_d = '0;
          w_state_d   = StShift;
        end
      end
      StShift: begin
        if (r_bit_cnt == LastBit) begin
          if (r_rep != '0) begin
            // Reload for the next repetition with no idle gap.
            w_rep_d     = r_rep - CNT_W'(1);
            w_shift_d   = r_shadow;
            w_bit_cnt_d = '0;
          end else begin
            w_state_d = StDone;
          end
        end else begin
          w_shift_d   = {r_shift[WIDTH-2:0], 1'b0};
          w_bit_cnt_d = r_bit_cnt + BitW'(1);
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs are registered from next-state values so they align with the state they describe.
  always_comb begin
`ifdef SEQGEN_PARITY_EN
    w_tx_bit = (w_bit_cnt_d == LastBit) ? ^w_shadow_d : w_shift_d[WIDTH-1];
`else
    w_tx_bit = w_shift_d[WIDTH-1];
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_shadow     <= '0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_rep        <= '0;
      r_serial     <= 1'b0;
      r_bit_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_load_ready <= 1'b1;
    end else begin
      r_state      <= w_state_d;
      r_shadow     <= w_shadow_d;
      r_shift      <= w_shift_d;
      r_bit_cnt    <= w_bit_cnt_d;
      r_rep        <= w_rep_d;
      r_serial     <= (w_state_d == StShift) ? w_tx_bit : 1'b0;
      r_bit_valid  <= (w_state_d == StShift);
      r_busy       <= (w_state_d == StShift);
      r_done       <= (w_state_d == StDone);
      r_load_ready <= (w_state_d == StIdle);
    end
  end

  assign serialOutput = r_serial;
  assign bit_valid    = r_bit_valid;
  assign busy         = r_busy;
  assign done         = r_done;
  assign load_ready   = r_load_ready;

endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboard bench for sequence_generator: expected bits are queued at each load and
// compared as the DUT emits valid bits.
module tb_sequence_generator;

`ifdef SEQGEN_PARITY_EN
  localparam int Par = 1;
`else
  localparam int Par = 0;
`endif
  localparam int W = 8;

  logic       clk;
  logic       reset_n;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] pattern;
  logic [3:0] repeat_cnt;
  logic       serialOutput;
  logic       bit_valid;
  logic       busy;
  logic       done;

  int   n_total;
  int   n_bad;
  bit   mon_en;
  bit   exp_q[$];

  sequence_generator #(.WIDTH(8), .CNT_W(4)) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .pattern      (pattern),
    .repeat_cnt   (repeat_cnt),
    .serialOutput (serialOutput),
    .bit_valid    (bit_valid),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bit_valid === 1'b1) begin
        if (exp_q.size() == 0) check_val("extra_bit", 32'(serialOutput), 32'd2);
        else check_val("bit", 32'(serialOutput), 32'(exp_q.pop_front()));
      end else begin
        check_val("idle_zero", 32'(serialOutput), 32'd0);
      end
    end
  end

  task automatic push_expected(input logic [7:0] pat, input logic [3:0] rep);
    for (int r = 0; r <= int'(rep); r++) begin
      for (int i = W - 1; i >= 0; i--) exp_q.push_back(pat[i]);
      if (Par != 0) exp_q.push_back(^pat);
    end
  endtask

  task automatic do_load(input logic [7:0] pat, input logic [3:0] rep, output int waited);
    waited = 0;
    @(negedge clk);
    while (load_ready !== 1'b1 && waited < 400) begin
      waited++;
      @(negedge clk);
    end
    if (load_ready !== 1'b1) check_val("load_ready_timeout", 32'(load_ready), 32'd1);
    load_valid = 1'b1;
    pattern    = pat;
    repeat_cnt = rep;
    push_expected(pat, rep);
    @(posedge clk);
    #1 load_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc, output int busy_n);
    bit seen;
    seen   = 0;
    cyc    = 0;
    busy_n = 0;
    while (!seen && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) seen = 1;
    end
    if (!seen) check_val("done_timeout", 32'd0, 32'd1);
  endtask

  function automatic int nbits(input int rep);
    return (rep + 1) * (W + Par);
  endfunction

  initial begin
    int waited, cyc, busy_n, seen_done;
    n_total    = 0;
    n_bad      = 0;
    mon_en     = 0;
    reset_n    = 1'b0;
    load_valid = 1'b0;
    pattern    = '0;
    repeat_cnt = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_serial", 32'(serialOutput), 32'd0);
    check_val("rst_valid", 32'(bit_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_ready", 32'(load_ready), 32'd1);
    reset_n = 1'b1;
    mon_en  = 1;

    // Single send
    do_load(8'b1001_0000, 4'd0, waited);
    wait_done(100, cyc, busy_n);
    check_val("single_done_cyc", 32'(cyc), 32'(nbits(0) + 1));
    check_val("single_busy", 32'(busy_n), 32'(nbits(0)));
    @(negedge clk);
    check_val("single_ready", 32'(load_ready), 32'd1);
    check_val("single_done_pulse", 32'(done), 32'd0);

    // Repeat x3
    do_load(8'hA5, 4'd2, waited);
    wait_done(200, cyc, busy_n);
    check_val("rep_done_cyc", 32'(cyc), 32'(nbits(2) + 1));
    check_val("rep_busy", 32'(busy_n), 32'(nbits(2)));

    // Load attempt while busy must be ignored
    do_load(8'h3C, 4'd0, waited);
    repeat (3) @(negedge clk);
    load_valid = 1'b1;
    pattern    = 8'hFF;
    repeat_cnt = 4'd5;
    repeat (2) @(negedge clk);
    load_valid = 1'b0;
    wait_done(100, cyc, busy_n);
    check_val("ign_done_cyc", 32'(cyc), 32'(nbits(0) + 1 - 5));
    check_val("ign_busy", 32'(busy_n), 32'(nbits(0) - 5));

    // Reset mid-transfer
    do_load(8'hC3, 4'd1, waited);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1 exp_q.delete();
    check_val("mid_rst_valid", 32'(bit_valid), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_ready", 32'(load_ready), 32'd1);
    @(negedge clk);
    reset_n   = 1'b1;
    seen_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
    end
    check_val("mid_rst_no_done", 32'(seen_done), 32'd0);
    do_load(8'h5A, 4'd0, waited);
    check_val("mid_rst_reload_wait", 32'(waited), 32'd0);
    wait_done(100, cyc, busy_n);
    check_val("reload_done_cyc", 32'(cyc), 32'(nbits(0) + 1));

    // Max repeat count, then back-to-back load right after done
    do_load(8'h81, 4'hF, waited);
    wait_done(400, cyc, busy_n);
    check_val("max_done_cyc", 32'(cyc), 32'(nbits(15) + 1));
    check_val("max_busy", 32'(busy_n), 32'(nbits(15)));
    do_load(8'h07, 4'd0, waited);
    check_val("b2b_gap", 32'(waited), 32'd0);
    wait_done(100, cyc, busy_n);
    check_val("p07_done_cyc", 32'(cyc), 32'(nbits(0) + 1));
    check_val("p07_busy", 32'(busy_n), 32'(nbits(0)));

    @(negedge clk);
    check_val("q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
